// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue
//   A DEPTH-entry circular instruction queue between fetch and decode,
//   followed by the decode-stage output register. Fetch keeps running while
//   decode is stalled until the queue fills. When the queue is empty and
//   decode is free, a valid fetch goes straight into the decode register,
//   which gives the same one-cycle latency as a plain F->D pipeline register.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   validF, pcF, instr, PCPlus4F, branch_predictF
//                     fetch-side instruction bundle
//   StallD, FlushD    hazard-unit controls (FlushD wins over StallD)
//   instrD, pcD, PCPlus4D, branch_predictD, validD
//                     decode-stage register outputs
//   fullF             queue full; fetch must hold its PC
//   countF            queue occupancy
//
// Optional feature, enabled by defining FETCH_DECODE_QUEUE_PERF_EN:
//   bubble_cnt        saturating count of bubbles loaded into decode
//   max_countF        high-water mark of countF
//   Both are cleared only by rst.
module fetch_decode_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         validF,
    input  logic [DATA_WIDTH-1:0]        pcF,
    input  logic [DATA_WIDTH-1:0]        instr,
    input  logic [DATA_WIDTH-1:0]        PCPlus4F,
    input  logic                         branch_predictF,
    input  logic                         StallD,
    input  logic                         FlushD,
    output logic [DATA_WIDTH-1:0]        instrD,
    output logic [DATA_WIDTH-1:0]        pcD,
    output logic [DATA_WIDTH-1:0]        PCPlus4D,
    output logic                         branch_predictD,
    output logic                         validD,
    output logic                         fullF,
    output logic [$clog2(DEPTH+1)-1:0]   countF
`ifdef FETCH_DECODE_QUEUE_PERF_EN
    ,
    output logic [31:0]                  bubble_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   max_countF
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] pcplus4;
        logic                  bp;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        f_entry;
    entry_t        head_entry;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        dreg_q, dreg_d;
    logic          valid_q, valid_d;

    logic          full;
    logic          empty;
    logic          do_pop;
    logic          do_bypass;
    logic          do_bubble;
    logic          do_push;
    logic          wr_en;

    assign f_entry    = '{instr: instr, pc: pcF, pcplus4: PCPlus4F, bp: branch_predictF};
    assign head_entry = mem[head_q];

    // Fullness comes from registered occupancy only, so a pop in the same
    // cycle never frees a slot for a push into a full queue.
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_pop    = !StallD && !empty;
    assign do_bypass = !StallD && empty && validF;
    assign do_bubble = !StallD && empty && !validF;
    assign do_push   = validF && !full && !do_bypass;
    assign wr_en     = do_push && !FlushD;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        dreg_d  = dreg_q;
        valid_d = valid_q;
        if (FlushD) begin
            // Squash everything; the PC fields are kept for debug visibility.
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            dreg_d.instr = NOP_INSTR;
            dreg_d.bp    = 1'b0;
            valid_d      = 1'b0;
        end else begin
            // DEPTH is a power of two, so plain pointer overflow wraps.
            if (do_push) tail_d = tail_q + PW'(1);
            if (do_pop)  head_d = head_q + PW'(1);
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (do_pop) begin
                dreg_d  = head_entry;
                valid_d = 1'b1;
            end else if (do_bypass) begin
                dreg_d  = f_entry;
                valid_d = 1'b1;
            end else if (do_bubble) begin
                dreg_d.instr = NOP_INSTR;
                dreg_d.bp    = 1'b0;
                valid_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            dreg_q  <= '{instr: NOP_INSTR, pc: '0, pcplus4: '0, bp: 1'b0};
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dreg_q  <= dreg_d;
            valid_q <= valid_d;
        end
    end

    // Queue storage carries no reset; stale entries are never read because
    // occupancy gates every pop.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[tail_q] <= f_entry;
        end
    end

    assign instrD          = dreg_q.instr;
    assign pcD             = dreg_q.pc;
    assign PCPlus4D        = dreg_q.pcplus4;
    assign branch_predictD = dreg_q.bp;
    assign validD          = valid_q;
    assign fullF           = full;
    assign countF          = count_q;

`ifdef FETCH_DECODE_QUEUE_PERF_EN
    logic [31:0]   bubble_cnt_q, bubble_cnt_d;
    logic [CW-1:0] max_count_q, max_count_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        max_count_d  = max_count_q;
        if (do_bubble && !FlushD && (bubble_cnt_q != '1)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
        // Track the occupancy being written so max_countF never trails countF.
        if (count_d > max_count_q) begin
            max_count_d = count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
            max_count_q  <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            max_count_q  <= max_count_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign max_countF = max_count_q;
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
module tb_fetch_decode_queue;

    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic          validF;
    logic [DW-1:0] pcF;
    logic [DW-1:0] instr;
    logic [DW-1:0] PCPlus4F;
    logic          branch_predictF;
    logic          StallD;
    logic          FlushD;
    logic [DW-1:0] instrD;
    logic [DW-1:0] pcD;
    logic [DW-1:0] PCPlus4D;
    logic          branch_predictD;
    logic          validD;
    logic          fullF;
    logic [CW-1:0] countF;
`ifdef FETCH_DECODE_QUEUE_PERF_EN
    logic [31:0]   bubble_cnt;
    logic [CW-1:0] max_countF;
`endif

    fetch_decode_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .validF(validF), .pcF(pcF), .instr(instr),
        .PCPlus4F(PCPlus4F), .branch_predictF(branch_predictF),
        .StallD(StallD), .FlushD(FlushD), .instrD(instrD), .pcD(pcD),
        .PCPlus4D(PCPlus4D), .branch_predictD(branch_predictD),
        .validD(validD), .fullF(fullF), .countF(countF)
`ifdef FETCH_DECODE_QUEUE_PERF_EN
        , .bubble_cnt(bubble_cnt), .max_countF(max_countF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Every field of a fetched instruction is a distinct function of its PC,
    // so any field mix-up or reordering shows up in the outputs.
    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic vf, input logic st, input logic fl,
                         input logic [31:0] pc);
        rst             = r;
        validF          = vf;
        StallD          = st;
        FlushD          = fl;
        pcF             = pc;
        instr           = mk_instr(pc);
        PCPlus4F        = pc + 32'd4;
        branch_predictF = pc[2];
    endtask

    typedef struct {
        logic        rst;
        logic        vf;
        logic        st;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] e_pc;
        logic        e_v;
        int          e_cnt;
        logic        e_full;
    } vec_t;

    vec_t tbl[34];

    // Behavioural reference: the queue is an SV queue of PCs, the decode
    // register is a handful of variables.
    logic [31:0] m_q[$];
    logic [31:0] m_pc, m_pc4, m_instr;
    logic        m_bp, m_valid;
    int          m_bub, m_max;

    task automatic model_load(input logic [31:0] pc);
        m_pc    = pc;
        m_pc4   = pc + 32'd4;
        m_instr = mk_instr(pc);
        m_bp    = pc[2];
        m_valid = 1'b1;
    endtask

    task automatic model_step();
        bit was_full;
        if (rst) begin
            m_q.delete();
            m_pc = 0; m_pc4 = 0; m_instr = NOP; m_bp = 0; m_valid = 0;
            m_bub = 0; m_max = 0;
        end else if (FlushD) begin
            m_q.delete();
            m_instr = NOP; m_bp = 0; m_valid = 0;
        end else begin
            was_full = (m_q.size() == DEPTH);
            if (!StallD) begin
                if (m_q.size() > 0) begin
                    model_load(m_q.pop_front());
                    if (validF && !was_full) m_q.push_back(pcF);
                end else if (validF) begin
                    model_load(pcF);
                end else begin
                    m_instr = NOP; m_bp = 0; m_valid = 0;
                    m_bub++;
                end
            end else if (validF && !was_full) begin
                m_q.push_back(pcF);
            end
            if (m_q.size() > m_max) m_max = m_q.size();
        end
    endtask

    initial begin
        logic [31:0] e_pc4;
        logic [31:0] next_pc;

        tbl[0]  = '{0,1,0,0,32'h000, 32'h000,1,0,0};
        tbl[1]  = '{0,1,0,0,32'h004, 32'h004,1,0,0};
        tbl[2]  = '{0,1,0,0,32'h008, 32'h008,1,0,0};
        tbl[3]  = '{0,1,1,0,32'h100, 32'h008,1,1,0};
        tbl[4]  = '{0,1,1,0,32'h104, 32'h008,1,2,0};
        tbl[5]  = '{0,1,1,0,32'h108, 32'h008,1,3,0};
        tbl[6]  = '{0,1,1,0,32'h10C, 32'h008,1,4,1};
        tbl[7]  = '{0,1,1,0,32'h110, 32'h008,1,4,1};
        tbl[8]  = '{0,1,1,0,32'h114, 32'h008,1,4,1};
        tbl[9]  = '{0,0,0,0,32'h000, 32'h100,1,3,0};
        tbl[10] = '{0,0,0,0,32'h000, 32'h104,1,2,0};
        tbl[11] = '{0,0,0,0,32'h000, 32'h108,1,1,0};
        tbl[12] = '{0,0,0,0,32'h000, 32'h10C,1,0,0};
        tbl[13] = '{0,1,0,0,32'h200, 32'h200,1,0,0};
        tbl[14] = '{0,0,0,0,32'h000, 32'h200,0,0,0};
        tbl[15] = '{0,0,0,0,32'h000, 32'h200,0,0,0};
        tbl[16] = '{0,1,1,0,32'h014, 32'h200,0,1,0};
        tbl[17] = '{0,1,1,0,32'h018, 32'h200,0,2,0};
        tbl[18] = '{0,1,0,0,32'h01C, 32'h014,1,2,0};
        tbl[19] = '{0,1,0,0,32'h020, 32'h018,1,2,0};
        tbl[20] = '{0,1,0,0,32'h024, 32'h01C,1,2,0};
        tbl[21] = '{0,1,0,0,32'h028, 32'h020,1,2,0};
        tbl[22] = '{0,0,0,0,32'h000, 32'h024,1,1,0};
        tbl[23] = '{0,0,0,0,32'h000, 32'h028,1,0,0};
        tbl[24] = '{0,1,1,0,32'h300, 32'h028,1,1,0};
        tbl[25] = '{0,1,1,0,32'h304, 32'h028,1,2,0};
        tbl[26] = '{0,1,1,0,32'h308, 32'h028,1,3,0};
        tbl[27] = '{0,1,1,1,32'h30C, 32'h028,0,0,0};
        tbl[28] = '{0,1,0,0,32'h310, 32'h310,1,0,0};
        tbl[29] = '{0,1,1,0,32'h400, 32'h310,1,1,0};
        tbl[30] = '{0,1,1,0,32'h404, 32'h310,1,2,0};
        tbl[31] = '{0,1,1,0,32'h408, 32'h310,1,3,0};
        tbl[32] = '{0,1,1,0,32'h40C, 32'h310,1,4,1};
        tbl[33] = '{1,1,1,0,32'h410, 32'h000,0,0,0};

        drive(1, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_instrD", instrD, NOP);
        chk("reset_validD", {31'd0, validD}, 0);
        chk("reset_pcD", pcD, 0);
        chk("reset_countF", 32'(countF), 0);
        chk("reset_fullF", {31'd0, fullF}, 0);

        for (int i = 0; i < 34; i++) begin
            drive(tbl[i].rst, tbl[i].vf, tbl[i].st, tbl[i].fl, tbl[i].pc);
            @(posedge clk);
            #1;
            e_pc4 = (tbl[i].e_v || tbl[i].e_pc != 0) ? tbl[i].e_pc + 32'd4 : 32'd0;
            chk($sformatf("v%0d_pcD", i), pcD, tbl[i].e_pc);
            chk($sformatf("v%0d_validD", i), {31'd0, validD}, {31'd0, tbl[i].e_v});
            chk($sformatf("v%0d_countF", i), 32'(countF), tbl[i].e_cnt);
            chk($sformatf("v%0d_fullF", i), {31'd0, fullF}, {31'd0, tbl[i].e_full});
            chk($sformatf("v%0d_instrD", i), instrD, tbl[i].e_v ? mk_instr(tbl[i].e_pc) : NOP);
            chk($sformatf("v%0d_bpD", i), {31'd0, branch_predictD},
                {31'd0, tbl[i].e_v & tbl[i].e_pc[2]});
            chk($sformatf("v%0d_PCPlus4D", i), PCPlus4D, e_pc4);
`ifdef FETCH_DECODE_QUEUE_PERF_EN
            if (i == 8)  chk("perf_max_full", 32'(max_countF), 4);
            if (i == 15) chk("perf_bubble_cnt", bubble_cnt, 2);
            if (i == 33) chk("perf_max_after_rst", 32'(max_countF), 0);
`endif
            $display("vec %0d: pcF=%h vf=%0d st=%0d fl=%0d rst=%0d -> pcD=%h validD=%0d countF=%0d",
                     i, tbl[i].pc, tbl[i].vf, tbl[i].st, tbl[i].fl, tbl[i].rst, pcD, validD, countF);
        end

        // Randomised run against the reference model, starting from reset.
        next_pc = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            drive((c == 0) || ($urandom_range(0, 199) == 0),
                  $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 19) == 0,
                  next_pc);
            next_pc = next_pc + 32'd4;
            model_step();
            @(posedge clk);
            #1;
            chk("rnd_pcD", pcD, m_pc);
            chk("rnd_PCPlus4D", PCPlus4D, m_pc4);
            chk("rnd_instrD", instrD, m_instr);
            chk("rnd_bpD", {31'd0, branch_predictD}, {31'd0, m_bp});
            chk("rnd_validD", {31'd0, validD}, {31'd0, m_valid});
            chk("rnd_countF", 32'(countF), m_q.size());
            chk("rnd_fullF", {31'd0, fullF}, (m_q.size() == DEPTH) ? 32'd1 : 32'd0);
`ifdef FETCH_DECODE_QUEUE_PERF_EN
            chk("rnd_bubble_cnt", bubble_cnt, m_bub);
            chk("rnd_max_countF", 32'(max_countF), m_max);
`endif
            if (c % 100 == 0)
                $display("rnd %0d: pcD=%h validD=%0d countF=%0d", c, pcD, validD, countF);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
